bsg_cache_sbuf_ctrl: RTL
========================

// Module: bsg_cache_sbuf_ctrl
// PURPOSE
//  Two-entry store buffer for the cache. Accepts write (addr/data/mask) from the cache tag-lookup stage and
//  presents them in order to the data-mem write port. Holds a two-element datapath queue and drives its
//  el0/el1 enables and mux selects. Fall-through when empty. Gives a byte-masked bypass of buffered stores
//  to loads that hit the same word.
// PARAMETERS
//  data_width_p  16                 store data width, bits (multiple of 8)
//  addr_width_p  12                 byte address width
//  mask_width_p  data_width_p/8     byte-enable width (derived, do not override)
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  reset_n_i      in   1   asynchronous active-low reset
//  v_i            in   1   store valid
//  addr_i         in   addr_width_p  store byte address
//  data_i         in   data_width_p  store data
//  mask_i         in   mask_width_p  store byte enables
//  ready_o        out  1   store accepted when v_i&ready_o
//  v_o            out  1   head store valid to data-mem
//  addr_o         out  addr_width_p  head store address
//  data_o         out  data_width_p  head store data
//  mask_o         out  mask_width_p  head store mask
//  yumi_i         in   1   head consumed this cycle (only when v_o)
//  bypass_v_i     in   1   load lookup valid
//  bypass_addr_i  in   addr_width_p  load byte address
//  bypass_data_o  out  data_width_p  merged buffered bytes for load word
//  bypass_mask_o  out  mask_width_p  bytes supplied by buffer
//  empty_o        out  1   num_els==0
//  full_o         out  1   num_els==2
// BEHAVIOUR
//  - Reset (reset_n_i low, async): num_els_r=0. While asserted: ready_o=0, v_o=0, bypass_mask_o=0,
//    empty_o=1, full_o=0. Entry storage is not reset; validity comes only from num_els_r.
//  - ready_o = (num_els_r!=2). No combinational path from yumi_i to ready_o. in_acc = v_i&ready_o.
//  - el1 = head (oldest), el0 = second. Queue controls: mux1_sel=(num_els_r!=0) selects el1 vs input
//    for the output. mux0_sel selects el0 (1) vs input (0) as el1's next value.
//  - State EMPTY (0): v_o=v_i, output = input (zero-latency fall-through).
//      in_acc&yumi_i -> pass through, no write, stay 0. in_acc&~yumi_i -> el1<=input, ->1.
//  - State ONE (1): v_o=1, output=el1.
//      in_acc&yumi_i -> el1<=input, stay 1. in_acc&~yumi_i -> el0<=input, ->2.
//      ~in_acc&yumi_i -> ->0. neither -> hold.
//  - State TWO (2): v_o=1, output=el1, ready_o=0.
//      yumi_i -> el1<=el0 (mux0_sel=1), ->1. else hold.
//  - yumi_i with v_o=0 is illegal; assertion fires, state unchanged.
//  - Bypass (combinational, same cycle): word match = addr[aw-1:lg(mask_width_p)] equal, ignoring
//    byte offset. Candidates are valid entries only: el1 if num_els>=1, el0 if num_els==2. The
//    in-flight input is not a candidate. Per byte: el0 (newer) wins over el1. bypass_mask_o = OR of
//    matching entry masks. Unsupplied bytes of bypass_data_o = 0. bypass_v_i=0 -> mask 0.
//  - Bypass uses pre-edge state. A store retired by yumi_i in the same cycle still contributes.
//  - Reset mid-operation drops all buffered stores with no drain. First cycle after release is EMPTY.
// STRUCTURE
//  - bsg_cache_sbuf_pkg: sbuf_entry_s {addr,data,mask} typedef, num_els enum {EMPTY,ONE,TWO},
//    lg byte-offset constant.
//  - One sub-module: bsg_cache_sbuf_queue, width_p = addr+data+mask, carrying packed sbuf_entry_s.
//    This block holds only num_els_r, next-state/control decode and the bypass merge.
// TESTING (data_width_p=16, addr_width_p=12)
//  1 Reset release, v_i=1 addr=0x010 data=0xBEEF mask=11, yumi_i=1 -> same cycle v_o=1 data_o=0xBEEF;
//    empty_o stays 1.
//  2 Two stores 0x1111@0x020, 0x2222@0x022, yumi_i=0 -> full_o=1, ready_o=0. yumi_i two cycles ->
//    data_o 0x1111 then 0x2222, then empty_o=1.
//  3 State ONE, v_i&yumi_i every cycle for 8 cycles -> in-order output, num_els stays 1, no loss/duplicates.
//  4 Bypass: el1=0xAA00@0x040 mask=10, el0=0x00BB@0x040 mask=01, load 0x041 -> bypass_data_o=0xAABB
//    mask=11. Overlap: both mask=11 -> el0 data wins.
//  5 Bypass miss, load 0x042 -> bypass_mask_o=00. Bypass while yumi_i retires head -> head still merged.
//  6 Full queue, reset_n_i low mid-cycle -> v_o=0 immediately. After release empty_o=1, no stale output.

Source files
------------

// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared types for the cache store buffer: entry layout, occupancy encoding and the
// byte-offset width used when matching load words against buffered stores.
package bsg_cache_sbuf_pkg;

   localparam int SBUF_DATA_W  = 16;
   localparam int SBUF_ADDR_W  = 12;
   localparam int SBUF_MASK_W  = SBUF_DATA_W / 8;
   localparam int SBUF_LG_MASK = $clog2(SBUF_MASK_W);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } num_els_e;

   typedef struct packed {
      logic [SBUF_ADDR_W-1:0] addr;
      logic [SBUF_DATA_W-1:0] data;
      logic [SBUF_MASK_W-1:0] mask;
   } sbuf_entry_s;

   localparam int SBUF_ENTRY_W = $bits(sbuf_entry_s);

endpackage

// File: rtl/bsg_cache_sbuf_queue.sv
// Two-element datapath queue: el1 is the head, el0 the second slot. Storage carries no
// reset; occupancy is tracked by the controller.
module bsg_cache_sbuf_queue #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               el0_en_i,
   input  logic               el1_en_i,
   input  logic               mux0_sel_i,
   input  logic               mux1_sel_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o,
   output logic [width_p-1:0] el0_o,
   output logic [width_p-1:0] el1_o
);

   logic [width_p-1:0] r_el0;
   logic [width_p-1:0] r_el1;
   logic [width_p-1:0] w_el1_n;

   // el1 refills either from the second slot (advance) or straight from the input
   assign w_el1_n = mux0_sel_i ? r_el0 : data_i;

   always_ff @(posedge clk_i) begin
      if (el0_en_i) r_el0 <= data_i;
      if (el1_en_i) r_el1 <= w_el1_n;
   end

   assign data_o = mux1_sel_i ? r_el1 : data_i;
   assign el0_o  = r_el0;
   assign el1_o  = r_el1;

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Two-entry store buffer controller: occupancy FSM, queue enable/mux decode, and the
// byte-masked load bypass over buffered stores. Widths must match bsg_cache_sbuf_pkg.
module bsg_cache_sbuf_ctrl
   import bsg_cache_sbuf_pkg::*;
#(
   parameter  int data_width_p = SBUF_DATA_W,
   parameter  int addr_width_p = SBUF_ADDR_W,
   localparam int mask_width_p = data_width_p / 8
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,

   input  logic                    v_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  logic [data_width_p-1:0] data_i,
   input  logic [mask_width_p-1:0] mask_i,
   output logic                    ready_o,

   output logic                    v_o,
   output logic [addr_width_p-1:0] addr_o,
   output logic [data_width_p-1:0] data_o,
   output logic [mask_width_p-1:0] mask_o,
   input  logic                    yumi_i,

   input  logic                    bypass_v_i,
   input  logic [addr_width_p-1:0] bypass_addr_i,
   output logic [data_width_p-1:0] bypass_data_o,
   output logic [mask_width_p-1:0] bypass_mask_o,

   output logic                    empty_o,
   output logic                    full_o
);

   num_els_e    r_num_els;
   num_els_e    w_num_els_n;
   logic        w_in_acc;
   logic        w_el0_en;
   logic        w_el1_en;
   logic        w_mux0_sel;
   logic        w_mux1_sel;
   sbuf_entry_s w_in;
   sbuf_entry_s w_head;
   sbuf_entry_s w_el0;
   sbuf_entry_s w_el1;
   logic        w_hit0;
   logic        w_hit1;

   // Handshake outputs are forced quiet while reset is held, independent of the clock
   assign ready_o  = reset_n_i & (r_num_els != TWO);
   assign v_o      = reset_n_i & ((r_num_els != EMPTY) | v_i);
   assign empty_o  = (r_num_els == EMPTY);
   assign full_o   = (r_num_els == TWO);
   assign w_in_acc = v_i & ready_o;

   assign w_in.addr = addr_i;
   assign w_in.data = data_i;
   assign w_in.mask = mask_i;

   assign w_mux1_sel = (r_num_els != EMPTY);

   always_comb begin
      w_num_els_n = r_num_els;
      w_el0_en    = 1'b0;
      w_el1_en    = 1'b0;
      w_mux0_sel  = 1'b0;
      case (r_num_els)
         EMPTY: begin
            if (w_in_acc && !yumi_i) begin
               w_el1_en    = 1'b1;
               w_num_els_n = ONE;
            end
         end
         ONE: begin
            if (w_in_acc && yumi_i) begin
               w_el1_en    = 1'b1;
            end else if (w_in_acc) begin
               w_el0_en    = 1'b1;
               w_num_els_n = TWO;
            end else if (yumi_i) begin
               w_num_els_n = EMPTY;
            end
         end
         TWO: begin
            w_mux0_sel = 1'b1;
            if (yumi_i) begin
               w_el1_en    = 1'b1;
               w_num_els_n = ONE;
            end
         end
         default: w_num_els_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_num_els <= EMPTY;
      else            r_num_els <= w_num_els_n;
   end

   bsg_cache_sbuf_queue #(
      .width_p (SBUF_ENTRY_W)
   ) u_queue (
      .clk_i      (clk_i),
      .el0_en_i   (w_el0_en),
      .el1_en_i   (w_el1_en),
      .mux0_sel_i (w_mux0_sel),
      .mux1_sel_i (w_mux1_sel),
      .data_i     (w_in),
      .data_o     (w_head),
      .el0_o      (w_el0),
      .el1_o      (w_el1)
   );

   assign addr_o = w_head.addr;
   assign data_o = w_head.data;
   assign mask_o = w_head.mask;

   // Word match ignores byte offset; only occupied slots are candidates
   assign w_hit1 = bypass_v_i && (r_num_els != EMPTY)
                   && ((w_el1.addr >> SBUF_LG_MASK) == (bypass_addr_i >> SBUF_LG_MASK));
   assign w_hit0 = bypass_v_i && (r_num_els == TWO)
                   && ((w_el0.addr >> SBUF_LG_MASK) == (bypass_addr_i >> SBUF_LG_MASK));

   // el0 is the younger store, so it takes priority byte by byte
   always_comb begin
      bypass_data_o = '0;
      bypass_mask_o = '0;
      for (int b = 0; b < mask_width_p; b++) begin
         if (w_hit0 && w_el0.mask[b]) begin
            bypass_data_o[8*b +: 8] = w_el0.data[8*b +: 8];
            bypass_mask_o[b]        = 1'b1;
         end else if (w_hit1 && w_el1.mask[b]) begin
            bypass_data_o[8*b +: 8] = w_el1.data[8*b +: 8];
            bypass_mask_o[b]        = 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule
